ascon_aead_arbiter: RTL and testbench

//  Shares one Encryption core between two requesters (e.g. SoC bus and test port). Round-robin

---
 rtl/ascon_aead_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_ascon_aead_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_aead_arbiter.sv
// Purpose: round-robin share of one Ascon AEAD core between two requesters, with a watchdog on core completion.
// Latency: grant in cycle G, core_start at G+1, response valid the cycle after core done (or after timeout).
// Backpressure: req_ready only in IDLE; a response is held in RESP until the owner asserts rsp_ready.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready [1:0] per-requester request handshake; req_ready is the one-hot grant
//   req_key/nonce/ad/pt       packed operands, requester i at slice i
//   rsp_valid/rsp_ready [1:0] per-requester response handshake
//   rsp_ct/rsp_tag/rsp_err    response payload; err marks a timeout with ct/tag forced to zero
//   core_key/nonce/ad/pt      operands latched for the core, stable until the next grant
//   core_start                one-cycle start pulse to the core
//   core_ct/core_tag          core results, sampled when core_ready rises
//   core_ready                core done (level)
//   busy                      arbiter is not idle
module ascon_aead_arbiter #(
    parameter int unsigned K       = 128,
    parameter int unsigned L       = 16,
    parameter int unsigned Y       = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*K-1:0]   req_key,
    input  logic [255:0]     req_nonce,
    input  logic [2*L-1:0]   req_ad,
    input  logic [2*Y-1:0]   req_pt,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [Y-1:0]     rsp_ct,
    output logic [127:0]     rsp_tag,
    output logic             rsp_err,
    output logic [K-1:0]     core_key,
    output logic [127:0]     core_nonce,
    output logic [L-1:0]     core_ad,
    output logic [Y-1:0]     core_pt,
    output logic             core_start,
    input  logic [Y-1:0]     core_ct,
    input  logic [127:0]     core_tag,
    input  logic             core_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_CLR  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_grant_q, last_grant_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [K-1:0]   key_q, key_d;
    logic [127:0]   nonce_q, nonce_d;
    logic [L-1:0]   ad_q, ad_d;
    logic [Y-1:0]   pt_q, pt_d;
    logic           start_q, start_d;
    logic [1:0]     rsp_valid_q, rsp_valid_d;
    logic [Y-1:0]   rsp_ct_q, rsp_ct_d;
    logic [127:0]   rsp_tag_q, rsp_tag_d;
    logic           rsp_err_q, rsp_err_d;
    logic           busy_q, busy_d;

    logic [1:0]     grant;
    logic           win;
    logic           timeout_hit;

    // Round robin: a lone requester always wins; on contention the one
    // that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign win         = grant[1];
    assign timeout_hit = (cnt_q == TO_CNT);

    // Grant is combinational so a request can be accepted in the same cycle
    // it is raised; it is masked while reset is held so every output reads 0.
    assign req_ready = ((state_q == S_IDLE) && rst) ? grant : 2'b00;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        nonce_d      = nonce_q;
        ad_d         = ad_q;
        pt_d         = pt_q;
        start_d      = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_ct_d     = rsp_ct_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    key_d        = win ? req_key[2*K-1:K]     : req_key[K-1:0];
                    nonce_d      = win ? req_nonce[255:128]   : req_nonce[127:0];
                    ad_d         = win ? req_ad[2*L-1:L]      : req_ad[L-1:0];
                    pt_d         = win ? req_pt[2*Y-1:Y]      : req_pt[Y-1:0];
                    owner_d      = win;
                    last_grant_d = win;
                    start_d      = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                cnt_d   = 16'd1;
                state_d = S_WAIT_CLR;
            end
            S_WAIT_CLR: begin
                // The core still shows the previous done level until it
                // drops ready to acknowledge the start pulse.
                cnt_d = cnt_q + 16'd1;
                if (timeout_hit) begin
                    rsp_ct_d    = '0;
                    rsp_tag_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d     = S_RESP;
                end else if (!core_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                cnt_d = cnt_q + 16'd1;
                // Done is checked first so a result arriving on the last
                // allowed cycle is still returned.
                if (core_ready) begin
                    rsp_ct_d    = core_ct;
                    rsp_tag_d   = core_tag;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d     = S_RESP;
                end else if (timeout_hit) begin
                    rsp_ct_d    = '0;
                    rsp_tag_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            key_q        <= '0;
            nonce_q      <= '0;
            ad_q         <= '0;
            pt_q         <= '0;
            start_q      <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_ct_q     <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            nonce_q      <= nonce_d;
            ad_q         <= ad_d;
            pt_q         <= pt_d;
            start_q      <= start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_ct_q     <= rsp_ct_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign core_key   = key_q;
    assign core_nonce = nonce_q;
    assign core_ad    = ad_q;
    assign core_pt    = pt_q;
    assign core_start = start_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_ct     = rsp_ct_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ascon_aead_arbiter.sv
// Purpose: self-checking bench for ascon_aead_arbiter with a behavioural core and arbitration model.
// Latency: expects core_start one cycle after grant and response min(D,TIMEOUT)+2 cycles after grant.
// Backpressure: exercises held responses, ignored non-owner rsp_ready and deferred requests.
module tb_ascon_aead_arbiter;

    localparam int K  = 128;
    localparam int L  = 16;
    localparam int Y  = 16;
    localparam int TO = 24;

    logic           clk;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*K-1:0] req_key;
    logic [255:0]   req_nonce;
    logic [2*L-1:0] req_ad;
    logic [2*Y-1:0] req_pt;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready;
    logic [Y-1:0]   rsp_ct;
    logic [127:0]   rsp_tag;
    logic           rsp_err;
    logic [K-1:0]   core_key;
    logic [127:0]   core_nonce;
    logic [L-1:0]   core_ad;
    logic [Y-1:0]   core_pt;
    logic           core_start;
    logic [Y-1:0]   core_ct;
    logic [127:0]   core_tag;
    logic           core_ready;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Arbitration model: index of the requester that won last (reset value 1).
    int model_last = 1;

    // Behavioural core controls.
    int           core_delay = 4;
    logic [Y-1:0] core_ct_v;
    logic [127:0] core_tag_v;
    bit           core_busy = 0;

    // Observations gathered by start_op.
    logic [1:0]   obs_grant;
    int           obs_starts, obs_start_idx, obs_lat;
    logic [1:0]   obs_rv;
    logic [Y-1:0] obs_ct;
    logic [127:0] obs_tag;
    logic         obs_err;
    logic [K-1:0] obs_key;
    logic [127:0] obs_nonce;
    logic [L-1:0] obs_ad;
    logic [Y-1:0] obs_pt;
    logic         obs_busy;

    ascon_aead_arbiter #(.K(K), .L(L), .Y(Y), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_key    (req_key),
        .req_nonce  (req_nonce),
        .req_ad     (req_ad),
        .req_pt     (req_pt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_ct     (rsp_ct),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .core_key   (core_key),
        .core_nonce (core_nonce),
        .core_ad    (core_ad),
        .core_pt    (core_pt),
        .core_start (core_start),
        .core_ct    (core_ct),
        .core_tag   (core_tag),
        .core_ready (core_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core: drops ready the cycle after start, raises it with the result
    // core_delay cycles after the start cycle; shows garbage while working.
    initial begin
        core_ready = 1'b1;
        core_ct    = '0;
        core_tag   = '0;
        forever begin
            @(posedge clk); #1;
            if (core_start === 1'b1) begin
                core_busy = 1;
                @(posedge clk); #1;
                core_ready = 1'b0;
                core_ct    = ~core_ct_v;
                core_tag   = ~core_tag_v;
                repeat (core_delay - 1) begin
                    @(posedge clk); #1;
                end
                core_ready = 1'b1;
                core_ct    = core_ct_v;
                core_tag   = core_tag_v;
                core_busy  = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model_pick(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return 1 - model_last;
    endfunction

    function automatic int model_lat(input int d);
        return ((d < TO) ? d : TO) + 2;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 8; i++) begin
            req_key[i*32 +: 32]   = $urandom;
            req_nonce[i*32 +: 32] = $urandom;
        end
        for (int i = 0; i < 4; i++) core_tag_v[i*32 +: 32] = $urandom;
        req_ad    = $urandom;
        req_pt    = $urandom;
        core_ct_v = 16'($urandom);
    endtask

    // Raises v, waits for a grant, then follows the operation until a
    // response appears. Returns at the sample point of the first RESP cycle.
    task automatic start_op(input logic [1:0] v, input int d, input bit keep);
        obs_grant = 2'b00; obs_starts = 0; obs_start_idx = -1; obs_lat = -1;
        obs_rv = 2'b00; obs_busy = 1'b0;
        core_delay = d;
        req_valid  = v;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) tick();
            #2;
            if (req_ready != 2'b00) begin
                obs_grant = req_ready;
                break;
            end
        end
        if (obs_grant == 2'b00) return;
        if (core_start) obs_starts++;
        for (int idx = 1; idx < TO + 40; idx++) begin
            tick();
            if (idx == 1 && !keep) req_valid = 2'b00;
            #2;
            if (core_start) begin
                obs_starts++;
                if (obs_start_idx < 0) obs_start_idx = idx;
            end
            if (idx == 1) begin
                obs_key = core_key; obs_nonce = core_nonce; obs_ad = core_ad; obs_pt = core_pt;
                obs_busy = busy;
            end
            if (rsp_valid != 2'b00) begin
                obs_lat = idx; obs_rv = rsp_valid; obs_ct = rsp_ct; obs_tag = rsp_tag; obs_err = rsp_err;
                break;
            end
        end
    endtask

    task automatic finish_op(input int owner);
        tick();
        rsp_ready = (owner == 1) ? 2'b10 : 2'b01;
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic wait_core_idle();
        for (int c = 0; c < 200 && core_busy; c++) tick();
        if (core_busy) begin
            n_tests++; n_fail++;
            $display("FAIL core_idle: core model still busy after 200 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_key = '0; req_nonce = '0; req_ad = '0; req_pt = '0;
        core_ct_v = '0; core_tag_v = '0;
        #1 rst = 1'b0;
        #1 req_valid = 2'b11;
        #1;
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
        n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
        n_tests++; if ({busy, core_start, rsp_err} !== 3'b000) begin n_fail++; $display("FAIL rst_busy_start_err: got %b want 000", {busy, core_start, rsp_err}); end
        n_tests++; if ({rsp_ct, rsp_tag} !== '0) begin n_fail++; $display("FAIL rst_rsp_data: got %h %h want 0", rsp_ct, rsp_tag); end
        n_tests++; if ({core_key, core_nonce, core_ad, core_pt} !== '0) begin n_fail++; $display("FAIL rst_core_ops: got %h want 0", core_key); end
        tick(); tick();
        req_valid = 2'b00;
        rst = 1'b1;
        model_last = 1;
        tick();
    endtask

    task automatic test_single();
        rand_ops();
        core_ct_v = 16'hA5C3;
        start_op(2'b01, 20, 0);
        model_last = 0;
        n_tests++; if (obs_grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", obs_grant); end
        n_tests++; if (obs_starts != 1 || obs_start_idx != 1) begin n_fail++; $display("FAIL single_start: got %0d pulses at %0d want 1 at 1", obs_starts, obs_start_idx); end
        n_tests++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", obs_busy); end
        n_tests++; if (obs_key !== req_key[K-1:0] || obs_nonce !== req_nonce[127:0] || obs_ad !== req_ad[L-1:0] || obs_pt !== req_pt[Y-1:0]) begin
            n_fail++; $display("FAIL single_operands: got key %h want %h", obs_key, req_key[K-1:0]); end
        n_tests++; if (obs_lat != model_lat(20)) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", obs_lat, model_lat(20)); end
        n_tests++; if ({obs_rv, obs_err, obs_ct} !== {2'b01, 1'b0, 16'hA5C3}) begin n_fail++; $display("FAIL single_rsp: got rv %b err %b ct %h want 01 0 a5c3", obs_rv, obs_err, obs_ct); end
        n_tests++; if (obs_tag !== core_tag_v) begin n_fail++; $display("FAIL single_tag: got %h want %h", obs_tag, core_tag_v); end
        finish_op(0);
        #2;
        n_tests++; if ({rsp_valid, busy} !== 3'b000) begin n_fail++; $display("FAIL single_clear: got rv %b busy %b want 00 0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        int w;
        rst = 1'b0; tick(); rst = 1'b1; model_last = 1;
        for (int n = 0; n < 4; n++) begin
            rand_ops();
            w = model_pick(2'b11);
            start_op(2'b11, $urandom_range(2, 10), 1);
            n_tests++; if (obs_grant !== ((w == 1) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_grant%0d: got %b want requester %0d", n, obs_grant, w); end
            n_tests++; if (obs_key !== req_key[w*K +: K] || obs_rv !== obs_grant || obs_ct !== core_ct_v) begin
                n_fail++; $display("FAIL rr_data%0d: key %h rv %b ct %h want key %h ct %h", n, obs_key, obs_rv, obs_ct, req_key[w*K +: K], core_ct_v); end
            model_last = w;
            finish_op(w);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_timeout();
        int d;
        for (int n = 0; n < 3; n++) begin
            d = (n == 0) ? TO + 30 : ((n == 1) ? TO + 1 : TO);
            rand_ops();
            start_op(2'b10, d, 0);
            model_last = 1;
            n_tests++; if (obs_lat != model_lat(d)) begin n_fail++; $display("FAIL to_latency d=%0d: got %0d want %0d", d, obs_lat, model_lat(d)); end
            if (d > TO) begin
                n_tests++; if ({obs_rv, obs_err, obs_ct, obs_tag} !== {2'b10, 1'b1, 16'h0, 128'h0}) begin
                    n_fail++; $display("FAIL to_err d=%0d: got rv %b err %b ct %h tag %h want 10 1 0 0", d, obs_rv, obs_err, obs_ct, obs_tag); end
            end else begin
                n_tests++; if ({obs_rv, obs_err, obs_ct, obs_tag} !== {2'b10, 1'b0, core_ct_v, core_tag_v}) begin
                    n_fail++; $display("FAIL to_edge_done d=%0d: got rv %b err %b ct %h want 10 0 %h", d, obs_rv, obs_err, obs_ct, core_ct_v); end
            end
            finish_op(1);
            wait_core_idle();
        end
    endtask

    task automatic test_hold();
        logic [Y-1:0]   ct0;
        logic [127:0]   tag0;
        rand_ops();
        start_op(2'b01, 6, 0);
        model_last = 0;
        ct0 = core_ct_v; tag0 = core_tag_v;
        for (int c = 0; c < 10; c++) begin
            tick();
            rsp_ready = 2'b10;
            req_valid = 2'b11;
            #2;
            n_tests++; if ({rsp_valid, rsp_ct, req_ready, busy} !== {2'b01, ct0, 2'b00, 1'b1}) begin
                n_fail++; $display("FAIL hold_state c=%0d: rv %b ct %h rr %b busy %b want 01 %h 00 1", c, rsp_valid, rsp_ct, req_ready, busy, ct0); end
            n_tests++; if (rsp_tag !== tag0 || core_key !== req_key[K-1:0]) begin
                n_fail++; $display("FAIL hold_tag_key c=%0d: tag %h key %h want %h %h", c, rsp_tag, core_key, tag0, req_key[K-1:0]); end
        end
        finish_op(0);
        rand_ops();
        start_op(2'b11, 3, 0);
        n_tests++; if (obs_grant !== 2'b10 || obs_lat != model_lat(3)) begin
            n_fail++; $display("FAIL hold_deferred: grant %b lat %0d want 10 %0d", obs_grant, obs_lat, model_lat(3)); end
        model_last = 1;
        finish_op(1);
    endtask

    task automatic test_reset_mid();
        bit got;
        rand_ops();
        core_delay = 15;
        req_valid  = 2'b01;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            #2;
            if (req_ready == 2'b01) got = 1;
            tick();
        end
        req_valid = 2'b00;
        n_tests++; if (!got) begin n_fail++; $display("FAIL mid_grant: no grant seen, want 01"); end
        repeat (5) tick();
        #1;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        n_tests++; if ({req_ready, rsp_valid, core_start, busy, rsp_err} !== 7'b0) begin
            n_fail++; $display("FAIL mid_rst_ctrl: got %b want 0000000", {req_ready, rsp_valid, core_start, busy, rsp_err}); end
        n_tests++; if ({core_key, core_nonce, core_ad, core_pt, rsp_ct, rsp_tag} !== '0) begin
            n_fail++; $display("FAIL mid_rst_data: key %h ct %h want 0", core_key, rsp_ct); end
        tick();
        rst = 1'b1;
        model_last = 1;
        wait_core_idle();
        rand_ops();
        start_op(2'b11, 5, 0);
        n_tests++; if ({obs_grant, obs_rv, obs_err, obs_ct} !== {2'b01, 2'b01, 1'b0, core_ct_v} || obs_lat != model_lat(5)) begin
            n_fail++; $display("FAIL mid_after: grant %b rv %b err %b ct %h lat %0d want 01 01 0 %h %0d", obs_grant, obs_rv, obs_err, obs_ct, obs_lat, core_ct_v, model_lat(5)); end
        model_last = 0;
        finish_op(0);
    endtask

    task automatic test_random();
        logic [1:0] v;
        int d, w, hold;
        logic [Y-1:0]   ect;
        logic [127:0]   etag;
        for (int n = 0; n < 16; n++) begin
            v    = 2'($urandom_range(1, 3));
            d    = $urandom_range(2, TO + 3);
            hold = $urandom_range(0, 3);
            rand_ops();
            w = model_pick(v);
            start_op(v, d, 0);
            ect  = (d > TO) ? '0 : core_ct_v;
            etag = (d > TO) ? '0 : core_tag_v;
            n_tests++; if (obs_grant !== ((w == 1) ? 2'b10 : 2'b01) || obs_rv !== obs_grant) begin
                n_fail++; $display("FAIL rand_grant%0d v=%b: grant %b rv %b want requester %0d", n, v, obs_grant, obs_rv, w); end
            n_tests++; if (obs_starts != 1 || obs_start_idx != 1 || obs_lat != model_lat(d)) begin
                n_fail++; $display("FAIL rand_timing%0d d=%0d: starts %0d@%0d lat %0d want 1@1 %0d", n, d, obs_starts, obs_start_idx, obs_lat, model_lat(d)); end
            n_tests++; if (obs_err !== (d > TO) || obs_ct !== ect || obs_tag !== etag) begin
                n_fail++; $display("FAIL rand_rsp%0d d=%0d: err %b ct %h want err %b ct %h", n, d, obs_err, obs_ct, (d > TO), ect); end
            n_tests++; if (obs_key !== req_key[w*K +: K] || obs_nonce !== req_nonce[w*128 +: 128] || obs_ad !== req_ad[w*L +: L] || obs_pt !== req_pt[w*Y +: Y]) begin
                n_fail++; $display("FAIL rand_operands%0d: key %h pt %h want %h %h", n, obs_key, obs_pt, req_key[w*K +: K], req_pt[w*Y +: Y]); end
            model_last = w;
            repeat (hold) tick();
            finish_op(w);
            wait_core_idle();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
